// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: accepts a 128-bit state, substitutes LANES bytes per cycle
// from byte 15 down to byte 0, then presents the result under a valid/ready handshake.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 1  // 1, 2, 4, 8 or 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] InvSbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    state_e         state_q;
    logic [3:0]     cnt_q;      // bytes already substituted; current group starts at 15 - cnt_q
    logic [127:0]   data_q;
    logic [127:0]   sub_data;
    logic           last_group;

    // One table lookup per lane on the group of bytes selected by the counter.
    always_comb begin
        sub_data = data_q;
        for (int i = 0; i < int'(LANES); i++) begin
            sub_data[8*(15 - int'(cnt_q) - i) +: 8] =
                InvSbox[data_q[8*(15 - int'(cnt_q) - i) +: 8]];
        end
    end

    // Widened so LANES=16 does not wrap before the comparison.
    assign last_group = ((5'(cnt_q) + 5'(LANES)) == 5'd16);

    // Handshake signals decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StBusy: in_ready = 1'b0;
            StDone: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign out_data = data_q;

    // Control FSM with working register and byte counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            data_q  <= 128'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        cnt_q   <= 4'd0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    data_q <= sub_data;
                    cnt_q  <= cnt_q + 4'(LANES);
                    if (last_group) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Back-to-back accept on the same edge as the output handshake.
                            data_q  <= in_data;
                            cnt_q   <= 4'd0;
                            state_q <= StBusy;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream offers a 128-bit state.
REQ-005 SHALL have port in_ready  output  1  block can accept a state this cycle.
REQ-006 SHALL have port in_data  input  128  state to inverse-substitute; byte 15 = bits 127:120, byte 0 = bits 7:0.
REQ-007 SHALL have port out_valid  output  1  out_data holds a completed result.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-009 SHALL have port out_data  output  128  InvSubBytes(in_data), same byte ordering.

Function
REQ-010 SHALL implement states IDLE, BUSY and DONE.
REQ-011 In IDLE, in_ready SHALL be 1, out_valid 0.
REQ-012 Accept SHALL occur on a cycle with in_valid=1 and in_ready=1: capture in_data into a 128-bit working register, clear byte counter, go to BUSY.
REQ-013 In BUSY, each cycle SHALL replace LANES consecutive bytes of the working register with their FIPS-197 inverse S-box value, starting at byte 15 and descending.
REQ-014 The byte counter SHALL be 4-bit, advance by LANES per BUSY cycle, and transition to DONE on the cycle that processes byte 0.
REQ-015 Latency SHALL be exactly 16/LANES BUSY cycles; out_valid SHALL rise on the edge that completes the last group (LANES=1: out_valid high 16 cycles after the accept edge).
REQ-016 In BUSY, in_ready and out_valid SHALL both be 0; in_valid and in_data SHALL be ignored.
REQ-017 In DONE, out_valid SHALL be 1 and out_data SHALL be stable until the handshake completes.
REQ-018 Output handshake SHALL complete on a cycle with out_valid=1 and out_ready=1.
REQ-019 In DONE, in_ready SHALL equal out_ready; if in_valid=1 on the completing cycle, the new state SHALL be accepted and the FSM SHALL go directly to BUSY (back-to-back, no idle bubble).
REQ-020 In DONE, handshake completion without in_valid SHALL return the FSM to IDLE.
REQ-021 out_ready=0 in DONE SHALL hold state indefinitely without altering out_data.
REQ-022 out_data SHALL be driven from the working register; it is not required to be meaningful when out_valid=0.
REQ-023 The inverse S-box SHALL be a combinational 256-entry table instantiated LANES times; no multi-cycle lookup.

Reset
REQ-024 With rst=1 at a rising edge, the FSM SHALL enter IDLE and the counter SHALL clear, overriding any other input that cycle.
REQ-025 After reset, in_ready SHALL be 1, out_valid 0 and out_data 128'h0.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL abandon the operation with no out_valid pulse.

Verification
REQ-027 LANES=1, in_data=128'h7a9f102789d5f50b2beffd9f3dca4ea7, out_ready=1 -> out_valid high 16 cycles after accept, out_data=128'hbd6e7c3df2b5779e0b61216e8b10b689.
REQ-028 in_data all bytes 8'h63 -> out_data all 8'h00; in_data all 8'h00 -> out_data all 8'h52; in_data all 8'hff -> out_data all 8'h7d.
REQ-029 out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready 0; on out_ready=1 with in_valid=1 -> next state accepted same cycle, next result 16 cycles later.
REQ-030 rst pulsed at BUSY cycle 7 -> IDLE, out_valid never asserts; next accepted vector produces a correct result.
REQ-031 LANES=4 and LANES=16 with the REQ-027 vector -> identical out_data at latency 4 and 1 cycles respectively.
REQ-032 in_valid toggled during BUSY with differing in_data -> ignored; result equals InvSubBytes of the originally accepted state.
